// File: rtl/rcv_fifo_pkg.sv
// Shared sizes and types for the receive FIFO write side.
package rcv_fifo_pkg;

  localparam int RCV_FIFO_DEPTH = 3;
  localparam int RCV_PTR_W      = 2;
  localparam int RCV_DATA_W     = 8;

  typedef logic [RCV_PTR_W-1:0]  rcv_ptr_t;
  typedef logic [RCV_DATA_W-1:0] rcv_data_t;

endpackage

// File: rtl/rcv_fifo_tail_ctrl_flex_counter.sv
// fifo_flex_counter: wrapping index counter. Counts 0..rollover_val and
// returns to 0. rollover_flag is high while the count sits at rollover_val,
// so the owner can act on the wrapping edge itself.
module fifo_flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] count_d;

  // Next count: clear dominates, otherwise step and wrap at rollover_val.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/rcv_fifo_tail_ctrl.sv
// rcv_fifo_tail_ctrl: write side of the receive FIFO. Owns the tail index,
// its wrap toggle, the entry storage and the occupancy/overrun flags. The
// head index/toggle come from the separate head counter.
// Optional build macro RCV_FIFO_ALMOST_FULL_EN adds rcv_almost_full.
module rcv_fifo_tail_ctrl
  import rcv_fifo_pkg::*;
#(
  parameter int DEPTH  = RCV_FIFO_DEPTH,
  parameter int PTR_W  = RCV_PTR_W,
  parameter int DATA_W = RCV_DATA_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rcv_enq,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  head_ptr,
  input  logic              head_tog,
  input  logic              clear_err,
  output logic [DATA_W-1:0] rd_data,
  output logic [PTR_W-1:0]  tail_ptr,
  output logic              tail_tog,
  output logic              rcv_full,
  output logic              rcv_empty,
  output logic [PTR_W-1:0]  rcv_count,
  output logic              overrun_err
`ifdef RCV_FIFO_ALMOST_FULL_EN
  ,
  output logic              rcv_almost_full
`endif
);

  logic              accept;
  logic              rollover_flag;
  logic              tail_tog_q;
  logic              tail_tog_d;
  logic              overrun_q;
  logic              overrun_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W:0]    count_wide;

  // A write is only taken when there is room this cycle; a concurrent
  // dequeue does not create room until the head has actually moved.
  assign accept = rcv_enq && !rcv_full;

  fifo_flex_counter #(
    .NUM_CNT_BITS (PTR_W)
  ) u_tail_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (1'b0),
    .count_enable  (accept),
    .rollover_val  (PTR_W'(DEPTH - 1)),
    .count_out     (tail_ptr),
    .rollover_flag (rollover_flag)
  );

  // Toggle flips on the same edge the tail wraps; overrun set beats clear.
  always_comb begin
    tail_tog_d = tail_tog_q ^ (accept && rollover_flag);
    overrun_d  = overrun_q;
    if (clear_err) begin
      overrun_d = 1'b0;
    end
    if (rcv_enq && rcv_full) begin
      overrun_d = 1'b1;
    end
  end

  // Toggle and sticky error registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tail_tog_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      tail_tog_q <= tail_tog_d;
      overrun_q  <= overrun_d;
    end
  end

  // Storage next-state: only the entry at the tail takes the new data.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (accept && (tail_ptr == PTR_W'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  // Storage registers; cleared on reset so stale reads are deterministic.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read mux at the head index; an out-of-range head reads as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (head_ptr == PTR_W'(i)) begin
        rd_data = mem_q[i];
      end
    end
  end

  // Occupancy from the pointer pair, one bit wider to avoid wrap errors.
  always_comb begin
    if (tail_tog_q == head_tog) begin
      count_wide = {1'b0, tail_ptr} - {1'b0, head_ptr};
    end else begin
      count_wide = (PTR_W+1)'(DEPTH) - {1'b0, head_ptr} + {1'b0, tail_ptr};
    end
  end

  assign tail_tog    = tail_tog_q;
  assign overrun_err = overrun_q;
  assign rcv_count   = count_wide[PTR_W-1:0];
  assign rcv_empty   = (tail_ptr == head_ptr) && (tail_tog_q == head_tog);
  assign rcv_full    = (tail_ptr == head_ptr) && (tail_tog_q != head_tog);

`ifdef RCV_FIFO_ALMOST_FULL_EN
  assign rcv_almost_full = (rcv_count == PTR_W'(DEPTH - 1));
`endif

endmodule

// File: tb/tb_rcv_fifo_tail_ctrl.sv
// Bench for rcv_fifo_tail_ctrl. The head counter is emulated here; the
// reference model tracks totals written/read and a data queue.
module tb_rcv_fifo_tail_ctrl;

  logic       clk;
  logic       n_rst;
  logic       rcv_enq;
  logic [7:0] wr_data;
  logic [1:0] head_ptr;
  logic       head_tog;
  logic       clear_err;
  logic [7:0] rd_data;
  logic [1:0] tail_ptr;
  logic       tail_tog;
  logic       rcv_full;
  logic       rcv_empty;
  logic [1:0] rcv_count;
  logic       overrun_err;
`ifdef RCV_FIFO_ALMOST_FULL_EN
  logic       rcv_almost_full;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model
  int         wr_total;
  int         rd_total;
  logic       ovr_m;
  logic [7:0] q_m [$];

  rcv_fifo_tail_ctrl dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .rcv_enq     (rcv_enq),
    .wr_data     (wr_data),
    .head_ptr    (head_ptr),
    .head_tog    (head_tog),
    .clear_err   (clear_err),
    .rd_data     (rd_data),
    .tail_ptr    (tail_ptr),
    .tail_tog    (tail_tog),
    .rcv_full    (rcv_full),
    .rcv_empty   (rcv_empty),
    .rcv_count   (rcv_count),
    .overrun_err (overrun_err)
`ifdef RCV_FIFO_ALMOST_FULL_EN
    ,
    .rcv_almost_full (rcv_almost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_head();
    head_ptr = 2'((rd_total % 3));
    head_tog = 1'(((rd_total / 3) % 2));
  endtask

  task automatic compare_all(input string ctx);
    int cnt;
    cnt = wr_total - rd_total;
    chk({ctx, ".tail_ptr"}, 32'(tail_ptr), 32'(wr_total % 3));
    chk({ctx, ".tail_tog"}, 32'(tail_tog), 32'((wr_total / 3) % 2));
    chk({ctx, ".count"},    32'(rcv_count), 32'(cnt));
    chk({ctx, ".empty"},    32'(rcv_empty), 32'(cnt == 0));
    chk({ctx, ".full"},     32'(rcv_full), 32'(cnt == 3));
    chk({ctx, ".overrun"},  32'(overrun_err), 32'(ovr_m));
    if (q_m.size() > 0) begin
      chk({ctx, ".rd_data"}, 32'(rd_data), 32'(q_m[0]));
    end
`ifdef RCV_FIFO_ALMOST_FULL_EN
    chk({ctx, ".almost_full"}, 32'(rcv_almost_full), 32'(cnt == 2));
`endif
  endtask

  // One cycle: inputs applied at the negedge, head moves after the edge,
  // outputs compared at the following negedge.
  task automatic step(input logic e, input logic [7:0] d, input logic dq, input logic c);
    int  cnt;
    logic drop;
    rcv_enq   = e;
    wr_data   = d;
    clear_err = c;
    @(posedge clk);
    cnt  = wr_total - rd_total;
    drop = e && (cnt == 3);
    if (dq && cnt > 0) begin
      void'(q_m.pop_front());
      rd_total++;
    end
    if (e && !drop) begin
      q_m.push_back(d);
      wr_total++;
    end
    if (drop) ovr_m = 1'b1;
    else if (c) ovr_m = 1'b0;
    #1;
    drive_head();
    rcv_enq   = 1'b0;
    clear_err = 1'b0;
    @(negedge clk);
    compare_all("step");
  endtask

  task automatic model_reset();
    wr_total = 0;
    rd_total = 0;
    ovr_m    = 1'b0;
    q_m.delete();
  endtask

  task automatic check_reset_vals(input string ctx);
    chk({ctx, ".tail_ptr"}, 32'(tail_ptr), 32'd0);
    chk({ctx, ".tail_tog"}, 32'(tail_tog), 32'd0);
    chk({ctx, ".empty"},    32'(rcv_empty), 32'd1);
    chk({ctx, ".full"},     32'(rcv_full), 32'd0);
    chk({ctx, ".count"},    32'(rcv_count), 32'd0);
    chk({ctx, ".overrun"},  32'(overrun_err), 32'd0);
    chk({ctx, ".rd_data"},  32'(rd_data), 32'd0);
`ifdef RCV_FIFO_ALMOST_FULL_EN
    chk({ctx, ".almost_full"}, 32'(rcv_almost_full), 32'd0);
`endif
  endtask

  // Reset asserted between clock edges; checks happen before any edge.
  task automatic async_reset(input string ctx);
    @(posedge clk);
    #2;
    n_rst   = 1'b0;
    rcv_enq = 1'b0;
    model_reset();
    drive_head();
    #1;
    check_reset_vals(ctx);
    @(negedge clk);
    n_rst = 1'b1;
    compare_all({ctx, ".post"});
  endtask

  initial begin
    n_rst     = 1'b0;
    rcv_enq   = 1'b0;
    wr_data   = 8'h00;
    clear_err = 1'b0;
    model_reset();
    drive_head();
    #3;
    check_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    compare_all("idle");

    // Fill to full
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    chk("fill1.tail_ptr", 32'(tail_ptr), 32'd1);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    chk("fill2.tail_ptr", 32'(tail_ptr), 32'd2);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    chk("fill3.tail_ptr", 32'(tail_ptr), 32'd0);
    chk("fill3.tail_tog", 32'(tail_tog), 32'd1);
    chk("fill3.full",     32'(rcv_full), 32'd1);
    chk("fill3.count",    32'(rcv_count), 32'd3);
    chk("fill3.rd_data",  32'(rd_data), 32'hA1);

    // Overrun then clear
    step(1'b1, 8'hD4, 1'b0, 1'b0);
    chk("ovr.tail_ptr", 32'(tail_ptr), 32'd0);
    chk("ovr.flag",     32'(overrun_err), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr.flag",     32'(overrun_err), 32'd0);

    // Dequeue one, then refill entry 0
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("deq.full",  32'(rcv_full), 32'd0);
    chk("deq.count", 32'(rcv_count), 32'd2);
    step(1'b1, 8'hE5, 1'b0, 1'b0);
    chk("refill.rd_data", 32'(rd_data), 32'hB2);
    chk("refill.full",    32'(rcv_full), 32'd1);

    // Full + concurrent dequeue: enqueue still dropped, overrun set
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("fulldeq.overrun", 32'(overrun_err), 32'd1);
    chk("fulldeq.count",   32'(rcv_count), 32'd2);

    // Count 1 with simultaneous enqueue and dequeue
    async_reset("rst1");
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b1, 1'b0);
    chk("encdeq.count",    32'(rcv_count), 32'd1);
    chk("encdeq.tail_ptr", 32'(tail_ptr), 32'd2);
    chk("encdeq.rd_data",  32'(rd_data), 32'h22);

    // Count 2, then asynchronous reset mid-stream
    step(1'b1, 8'h33, 1'b0, 1'b0);
    chk("cnt2.count", 32'(rcv_count), 32'd2);
    async_reset("rst2");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic       e;
      logic       dq;
      logic       c;
      logic [7:0] d;
      e  = ($urandom_range(0, 99) < 60);
      dq = ((wr_total - rd_total) > 0) && ($urandom_range(0, 99) < 45);
      c  = ($urandom_range(0, 99) < 10);
      d  = 8'($urandom);
      step(e, d, dq, c);
      if (i == 300) async_reset("rst_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rcv_fifo_tail_ctrl.md
Name: rcv_fifo_tail_ctrl

Overview:
Write side of the receive FIFO; pairs with the existing head counter, which advances head_ptr/head_tog on rcv_deq.
Owns the tail pointer, its wrap-toggle bit, the 3-entry storage array and the full/empty/count/overrun flags.
Sits between the receive datapath (producer) and the packet processing logic that dequeues via the head counter.

Parameters:
DEPTH, 3, number of FIFO entries; pointer wraps after index DEPTH-1.
PTR_W, 2, pointer width; must hold DEPTH-1.
DATA_W, 8, width of one FIFO entry.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
rcv_enq  input  1  enqueue request; wr_data is valid in the same cycle
wr_data  input  DATA_W  data to enqueue
head_ptr  input  PTR_W  read index from the head counter
head_tog  input  1  head wrap toggle from the head counter
clear_err  input  1  synchronous clear of the overrun flag
rd_data  output  DATA_W  storage entry at head_ptr (combinational read)
tail_ptr  output  PTR_W  next write index
tail_tog  output  1  tail wrap toggle
rcv_full  output  1  FIFO holds DEPTH entries
rcv_empty  output  1  FIFO holds 0 entries
rcv_count  output  PTR_W  occupancy, 0..DEPTH
overrun_err  output  1  sticky: an enqueue was dropped

Behaviour:
- Reset (n_rst low, asynchronous): tail_ptr=0, tail_tog=0, overrun_err=0, all storage entries=0. With head at reset: rcv_empty=1, rcv_full=0, rcv_count=0.
- Flags are combinational from the registered pointers:
  - empty = (tail_ptr==head_ptr) && (tail_tog==head_tog)
  - full = (tail_ptr==head_ptr) && (tail_tog!=head_tog)
  - count = tail_ptr-head_ptr when the toggles are equal; otherwise DEPTH-head_ptr+tail_ptr. Compute at PTR_W+1 bits and truncate.
- Accept = rcv_enq && !rcv_full, evaluated on the current-cycle full.
- On accept at a clock edge:
  - storage[tail_ptr] <= wr_data.
  - tail_ptr increments; at DEPTH-1 it wraps to 0 and tail_tog inverts in the same edge.
- Write-to-read latency: 1 cycle. Data enqueued at edge N appears on rd_data after edge N when head_ptr points at that entry.
- Enqueue while full: no write, pointers unchanged, overrun_err <= 1.
- Enqueue and dequeue in the same cycle:
  - If not full: both proceed and the count is unchanged.
  - If full: the enqueue is still dropped and overrun is set. There is no bypass on a concurrent dequeue.
- Enqueue while empty with a concurrent dequeue: the enqueue is accepted. The dequeue underflow is the head side's responsibility and is not checked here.
- clear_err: overrun_err <= 0. If a dropped enqueue occurs in the same cycle, set wins.
- rd_data is storage[head_ptr]. It is undefined-free (returns the stale entry) when empty.
- The pointer counter is an instance of fifo_flex_counter (NUM_CNT_BITS=PTR_W, rollover_val=DEPTH-1, clear tied 0, count_enable=accept). tail_tog toggles on accept && rollover_flag.
- Reset mid-operation: all state returns to reset values asynchronously and the stored data is discarded. The head counter resets on the same n_rst, so the flags stay coherent.

Optional Feature:
- Macro: RCV_FIFO_ALMOST_FULL_EN.
- Defined: adds output rcv_almost_full (1 bit), asserted combinationally when rcv_count==DEPTH-1. Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package rcv_fifo_pkg holds:
  - localparams RCV_FIFO_DEPTH=3, RCV_PTR_W=2, RCV_DATA_W=8
  - typedef rcv_ptr_t (logic [RCV_PTR_W-1:0])
  - typedef rcv_data_t (logic [RCV_DATA_W-1:0])
- Sub-module: the existing fifo_flex_counter provides the tail index. Toggle, storage and flags stay in this module.

Test Plan:
- Reset, then idle with head=0/tog=0 -> rcv_empty=1, rcv_full=0, rcv_count=0, tail_ptr=0, overrun_err=0.
- Three enqueues of 0xA1, 0xB2, 0xC3, head held -> tail_ptr sequence 1,2,0; tail_tog=1 after the third; rcv_full=1; rcv_count=3; rd_data=0xA1.
- Fourth enqueue of 0xD4 while full -> no write, tail_ptr stays 0, overrun_err=1; a clear_err pulse then gives overrun_err=0.
- With the FIFO full, dequeue by driving head_ptr=1, head_tog=0 -> rcv_full=0, rcv_count=2; an enqueue of 0xE5 is then accepted into entry 0 and rd_data=0xB2.
- Count 1 (head=0, tail=1), enq + deq in the same cycle (head moves to 1) -> rcv_count stays 1, tail_ptr=2, rd_data is the new entry.
- n_rst asserted mid-stream with count=2 -> all outputs return to reset values immediately, without waiting for a clock edge; RCV_FIFO_ALMOST_FULL_EN build: rcv_almost_full=1 exactly when rcv_count=2.
